// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between pipeline stage registers and the hazard controller.
// The master side drives stage information; the slave side returns register controls.
interface pipe_ctrl_if;
    logic [3:0]  D_iCode;
    logic [3:0]  D_rA;
    logic [3:0]  D_rB;
    logic        D_valid;
    logic [3:0]  E_iCode;
    logic [3:0]  E_dstM;
    logic        e_Cnd;
    logic [3:0]  M_iCode;
    logic [3:0]  W_iCode;
    logic        W_valid;
    logic        resume;

    logic        F_stall;
    logic        D_stall;
    logic        D_bubble;
    logic        E_bubble;
    logic        M_bubble;
    logic        W_stall;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] bubble_cnt;

    modport master (
        output D_iCode, D_rA, D_rB, D_valid, E_iCode, E_dstM, e_Cnd,
               M_iCode, W_iCode, W_valid, resume,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
               state, stall_cnt, bubble_cnt
    );

    modport slave (
        input  D_iCode, D_rA, D_rB, D_valid, E_iCode, E_dstM, e_Cnd,
               M_iCode, W_iCode, W_valid, resume,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
               state, stall_cnt, bubble_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard/stall controller for a five-stage pipeline with halt/resume state
// and saturating stall and bubble performance counters.
module pipe_ctrl (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);

    localparam logic [3:0] IHalt   = 4'h0;
    localparam logic [3:0] IJxx    = 4'h7;
    localparam logic [3:0] IRet    = 4'h9;
    localparam logic [3:0] IMrmovq = 4'h5;
    localparam logic [3:0] IPopq   = 4'hB;
    localparam logic [3:0] RNone   = 4'hF;

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StHalted = 2'b01
    } state_e;

    state_e state_q;
    logic [15:0] stall_cnt_q;
    logic [15:0] bubble_cnt_q;

    logic load_use;
    logic ret_busy;
    logic mispredict;
    logic halt_in_d;
    logic halt_entry;
    logic run_ctl;

    logic f_stall_run;
    logic d_stall_run;
    logic d_bubble_run;
    logic e_bubble_run;

    always_comb begin
        load_use   = ((bus.E_iCode == IMrmovq) || (bus.E_iCode == IPopq)) &&
                     (bus.E_dstM != RNone) &&
                     ((bus.E_dstM == bus.D_rA) || (bus.E_dstM == bus.D_rB));
        ret_busy   = (bus.D_iCode == IRet) || (bus.E_iCode == IRet) || (bus.M_iCode == IRet);
        mispredict = (bus.E_iCode == IJxx) && !bus.e_Cnd;
        halt_in_d  = bus.D_valid && (bus.D_iCode == IHalt);
        halt_entry = bus.W_valid && (bus.W_iCode == IHalt);
    end

    // load_use suppresses the ret bubble so D is never stalled and bubbled together.
    always_comb begin
        f_stall_run  = load_use | ret_busy | halt_in_d;
        d_stall_run  = load_use;
        d_bubble_run = mispredict | (ret_busy & ~load_use);
        e_bubble_run = mispredict | load_use;
    end

    // Reset forces RUN-style controls even if the state register still holds HALTED.
    assign run_ctl = rst || (state_q == StRun);

    always_comb begin
        if (run_ctl) begin
            bus.F_stall  = f_stall_run;
            bus.D_stall  = d_stall_run;
            bus.D_bubble = d_bubble_run;
            bus.E_bubble = e_bubble_run;
            bus.M_bubble = 1'b0;
            bus.W_stall  = 1'b0;
        end else begin
            bus.F_stall  = 1'b1;
            bus.D_stall  = 1'b1;
            bus.D_bubble = 1'b0;
            bus.E_bubble = 1'b1;
            bus.M_bubble = 1'b1;
            bus.W_stall  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            case (state_q)
                StRun: begin
                    // Halt entry wins over a simultaneous resume.
                    if (halt_entry) begin
                        state_q <= StHalted;
                    end
                    if (f_stall_run && (stall_cnt_q != 16'hFFFF)) begin
                        stall_cnt_q <= stall_cnt_q + 16'd1;
                    end
                    if ((d_bubble_run || e_bubble_run) && (bubble_cnt_q != 16'hFFFF)) begin
                        bubble_cnt_q <= bubble_cnt_q + 16'd1;
                    end
                end
                StHalted: begin
                    if (bus.resume) begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign bus.state      = state_q;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: table of combinational hazard vectors with a
// counter scoreboard, plus hand sequences for ret, halt/resume, saturation and reset.
module tb_pipe_ctrl;

    logic clk;
    logic rst;

    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d_icode;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       dv;
        logic [3:0] e_icode;
        logic [3:0] e_dstm;
        logic       cnd;
        logic [3:0] m_icode;
        logic [5:0] exp;  // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
    } vec_t;

    localparam int NumVec = 12;
    vec_t vecs [NumVec];

    int checks;
    int errors;
    logic [15:0] exp_stall;
    logic [15:0] exp_bubble;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble, bus.M_bubble, bus.W_stall};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.D_iCode = 4'h1;
        bus.D_rA    = 4'hF;
        bus.D_rB    = 4'hF;
        bus.D_valid = 1'b1;
        bus.E_iCode = 4'h1;
        bus.E_dstM  = 4'hF;
        bus.e_Cnd   = 1'b1;
        bus.M_iCode = 4'h1;
        bus.W_iCode = 4'h1;
        bus.W_valid = 1'b1;
        bus.resume  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_stall  = 16'd0;
        exp_bubble = 16'd0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        set_idle();

        //            d   rA    rB    dv    e     dstM  cnd   m     exp
        vecs[0]  = '{4'h1, 4'hF, 4'hF, 1'b1, 4'h1, 4'hF, 1'b1, 4'h1, 6'b000000};
        vecs[1]  = '{4'h6, 4'h3, 4'hF, 1'b1, 4'h5, 4'h3, 1'b1, 4'h1, 6'b110100};
        vecs[2]  = '{4'h6, 4'hF, 4'h2, 1'b1, 4'hB, 4'h2, 1'b1, 4'h1, 6'b110100};
        vecs[3]  = '{4'h1, 4'hF, 4'hF, 1'b1, 4'h5, 4'hF, 1'b1, 4'h1, 6'b000000};
        vecs[4]  = '{4'h6, 4'h1, 4'h2, 1'b1, 4'h7, 4'hF, 1'b0, 4'h1, 6'b001100};
        vecs[5]  = '{4'h6, 4'h1, 4'h2, 1'b1, 4'h7, 4'hF, 1'b1, 4'h1, 6'b000000};
        vecs[6]  = '{4'h9, 4'hF, 4'hF, 1'b1, 4'h1, 4'hF, 1'b1, 4'h1, 6'b101000};
        vecs[7]  = '{4'h1, 4'hF, 4'hF, 1'b1, 4'h1, 4'hF, 1'b1, 4'h9, 6'b101000};
        vecs[8]  = '{4'h9, 4'h9, 4'hF, 1'b1, 4'hB, 4'h9, 1'b1, 4'h1, 6'b110100};
        vecs[9]  = '{4'h0, 4'hF, 4'hF, 1'b1, 4'h1, 4'hF, 1'b1, 4'h1, 6'b100000};
        vecs[10] = '{4'h0, 4'hF, 4'hF, 1'b0, 4'h1, 4'hF, 1'b1, 4'h1, 6'b000000};
        vecs[11] = '{4'h1, 4'hF, 4'hF, 1'b1, 4'h7, 4'hF, 1'b0, 4'h9, 6'b101100};

        // Reset state, with load-use inputs present during reset
        tick();
        bus.E_iCode = 4'h5; bus.E_dstM = 4'h3; bus.D_rA = 4'h3;
        #1;
        check("rst_outs_comb", {10'd0, outs()}, {10'd0, 6'b110100});
        tick();
        check("rst_state", {14'd0, bus.state}, 16'd0);
        check("rst_stall_cnt", bus.stall_cnt, 16'd0);
        check("rst_bubble_cnt", bus.bubble_cnt, 16'd0);
        rst = 1'b0;
        set_idle();
        exp_stall  = 16'd0;
        exp_bubble = 16'd0;

        // Table vectors with counter scoreboard
        for (int i = 0; i < NumVec; i++) begin
            bus.D_iCode = vecs[i].d_icode;
            bus.D_rA    = vecs[i].ra;
            bus.D_rB    = vecs[i].rb;
            bus.D_valid = vecs[i].dv;
            bus.E_iCode = vecs[i].e_icode;
            bus.E_dstM  = vecs[i].e_dstm;
            bus.e_Cnd   = vecs[i].cnd;
            bus.M_iCode = vecs[i].m_icode;
            #1;
            check($sformatf("vec%0d_outs", i), {10'd0, outs()}, {10'd0, vecs[i].exp});
            tick();
            if (vecs[i].exp[5]) exp_stall = exp_stall + 16'd1;
            if (vecs[i].exp[3] || vecs[i].exp[2]) exp_bubble = exp_bubble + 16'd1;
            check($sformatf("vec%0d_stall_cnt", i), bus.stall_cnt, exp_stall);
            check($sformatf("vec%0d_bubble_cnt", i), bus.bubble_cnt, exp_bubble);
        end

        // ret walking D -> E -> M
        set_idle();
        do_reset();
        bus.D_iCode = 4'h9;
        #1; check("ret_d_outs", {10'd0, outs()}, {10'd0, 6'b101000});
        tick();
        bus.D_iCode = 4'h1; bus.E_iCode = 4'h9;
        #1; check("ret_e_outs", {10'd0, outs()}, {10'd0, 6'b101000});
        tick();
        bus.E_iCode = 4'h1; bus.M_iCode = 4'h9;
        #1; check("ret_m_outs", {10'd0, outs()}, {10'd0, 6'b101000});
        tick();
        set_idle();
        check("ret_stall_cnt", bus.stall_cnt, 16'd3);
        check("ret_bubble_cnt", bus.bubble_cnt, 16'd3);

        // Halt entry, frozen counters, halted outputs, resume
        bus.W_iCode = 4'h0;
        #1; check("halt_pre_outs", {10'd0, outs()}, {10'd0, 6'b000000});
        tick();
        bus.W_iCode = 4'h1;
        check("halt_state", {14'd0, bus.state}, 16'd1);
        bus.E_iCode = 4'h7; bus.e_Cnd = 1'b0; bus.D_iCode = 4'h9;
        #1; check("halt_outs", {10'd0, outs()}, {10'd0, 6'b110111});
        tick(); tick();
        check("halt_stall_frozen", bus.stall_cnt, 16'd3);
        check("halt_bubble_frozen", bus.bubble_cnt, 16'd3);
        check("halt_state_held", {14'd0, bus.state}, 16'd1);
        set_idle();
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        check("resume_state", {14'd0, bus.state}, 16'd0);

        // Resume alone in RUN does nothing; halt beats resume
        bus.resume = 1'b1;
        tick();
        check("resume_in_run", {14'd0, bus.state}, 16'd0);
        bus.W_iCode = 4'h0;
        tick();
        bus.W_iCode = 4'h1;
        check("halt_beats_resume", {14'd0, bus.state}, 16'd1);
        bus.resume = 1'b0;

        // Reset while halted: RUN-style outputs during reset, RUN after the edge
        rst = 1'b1;
        #1; check("rst_halted_outs", {10'd0, outs()}, {10'd0, 6'b000000});
        tick();
        rst = 1'b0;
        check("rst_halted_state", {14'd0, bus.state}, 16'd0);

        // Saturation: 65534 load-use cycles, then 3 more
        set_idle();
        bus.E_iCode = 4'h5; bus.E_dstM = 4'h3; bus.D_rA = 4'h3;
        for (int i = 0; i < 65534; i++) tick();
        check("sat_stall_pre", bus.stall_cnt, 16'hFFFE);
        tick(); tick(); tick();
        check("sat_stall", bus.stall_cnt, 16'hFFFF);
        check("sat_bubble", bus.bubble_cnt, 16'hFFFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("sat_rst_stall", bus.stall_cnt, 16'd0);
        check("sat_rst_bubble", bus.bubble_cnt, 16'd0);
        check("sat_rst_state", {14'd0, bus.state}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have ports D_iCode, D_rA, D_rB, input, 4 each, decode-stage icode and source registers.
REQ-004 SHALL have port D_valid, input, 1, decode stage holds a real instruction, not a bubble or reset fill.
REQ-005 SHALL have ports E_iCode, E_dstM, input, 4 each, execute-stage icode and load destination; 4'hF means none.
REQ-006 SHALL have port e_Cnd, input, 1, branch condition computed in execute.
REQ-007 SHALL have ports M_iCode, W_iCode, input, 4 each, memory- and writeback-stage icodes.
REQ-008 SHALL have port W_valid, input, 1, writeback holds a real instruction.
REQ-009 SHALL have port resume, input, 1, leave HALTED.
REQ-010 SHALL have ports F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, output, 1 each, pipeline-register controls.
REQ-011 SHALL have port state, output, 2, FSM state: RUN=2'b00, HALTED=2'b01.
REQ-012 SHALL have ports stall_cnt, bubble_cnt, output, 16 each, performance counters.

Function
REQ-013 SHALL use these icodes: halt=0, nop=1, jXX=7, call=8, ret=9, mrmovq=5, popq=4'hB.
REQ-014 SHALL define load_use = (E_iCode==5 or 4'hB) and E_dstM!=4'hF and (E_dstM==D_rA or E_dstM==D_rB).
REQ-015 SHALL define ret_busy = ret (9) present in D_iCode, E_iCode or M_iCode.
REQ-016 SHALL define mispredict = (E_iCode==7) and !e_Cnd.
REQ-017 SHALL define halt_in_D = D_valid and D_iCode==0.
REQ-018 SHALL, in RUN, drive outputs combinationally with zero latency:
- F_stall = load_use | ret_busy | halt_in_D
- D_stall = load_use
- D_bubble = mispredict | (ret_busy & !load_use)
- E_bubble = mispredict | load_use
- M_bubble = 0; W_stall = 0
REQ-019 SHALL give D_stall priority over D_bubble: D_stall and D_bubble are never both 1.
REQ-020 SHALL, in HALTED, drive F_stall=1, D_stall=1, E_bubble=1, M_bubble=1, W_stall=1, D_bubble=0, regardless of other inputs.
REQ-021 SHALL transition RUN->HALTED at the edge where W_valid=1 and W_iCode==0.
REQ-022 SHALL transition HALTED->RUN at the edge where resume=1; resume in RUN has no effect.
REQ-023 SHALL give halt entry priority when halt entry and resume are both asserted in RUN: next state is HALTED.
REQ-024 SHALL increment stall_cnt on each edge with F_stall=1 in RUN, saturating at 16'hFFFF.
REQ-025 SHALL increment bubble_cnt on each edge with (D_bubble|E_bubble)=1 in RUN, by 1 per cycle even if both are set, saturating at 16'hFFFF.
REQ-026 SHALL not change either counter in HALTED.
REQ-027 SHALL treat an unused encoding of state as HALTED for outputs and move it to RUN at the next edge.

Reset
REQ-028 SHALL, when rst=1 at an edge, set state=RUN, stall_cnt=0, bubble_cnt=0, overriding halt entry and resume.
REQ-029 SHALL, while rst=1, leave the control outputs as the combinational function of the RUN-state inputs; reset mid-HALTED returns to RUN on the next edge.

Verification
REQ-030 SHALL cover load-use: E_iCode=5, E_dstM=3, D_rA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; stall_cnt +1.
REQ-031 SHALL cover mispredict: E_iCode=7, e_Cnd=0, D_iCode=6 -> D_bubble=1, E_bubble=1, F_stall=0; bubble_cnt +1 only.
REQ-032 SHALL cover ret bubbles: ret held in D, then E, then M for 3 cycles -> F_stall=1 and D_bubble=1 each cycle; stall_cnt=3, bubble_cnt=3.
REQ-033 SHALL cover combined load-use plus ret: E_iCode=4'hB, E_dstM=9, D_iCode=9, D_rA=9 -> D_stall=1, D_bubble=0, E_bubble=1.
REQ-034 SHALL cover halt and resume: W_iCode=0, W_valid=1 -> state=01 next cycle with all stall/bubble outputs per REQ-020 and counters frozen; resume=1 -> state=00.
REQ-035 SHALL cover saturation and reset: stall_cnt preloaded to 16'hFFFE, 3 stall cycles -> 16'hFFFF; rst=1 -> both counters 0 and state=00 next edge.
